quadrature_encoder: RTL and testbench
=====================================

// Module: quadrature_encoder
// PURPOSE
//  - Generates two-phase quadrature A/B waveforms that emulate the paddle's rotary encoder.
//  - Input is a commanded paddle position in clicks; the block emits Gray-coded edges at a
//    fixed rate until its internal edge count reaches 4x that position.
//  - Drives the AI/demo paddle and the hardware-in-loop bench: A/B loop back into the
//    player input path, so CPU and human paddles share one decode chain.
// PARAMETERS
//  STEP_DIV    1000  CLOCK cycles between successive A/B edges (>=2)
//  MAX_CLICKS  25    highest commandable position, in clicks; TARGET is clamped to this
//  WIDTH       8     width of TARGET and EDGE_COUNT
// PORTS
//  CLOCK       in   1      system clock; all logic on rising edge
//  RESET       in   1      synchronous, active-high reset
//  TARGET      in   WIDTH  commanded position in clicks; sampled only when LOAD=1
//  LOAD        in   1      1-cycle strobe: latch TARGET and start/retarget motion
//  A           out  1      quadrature phase A, registered
//  B           out  1      quadrature phase B, registered
//  BUSY        out  1      1 while in RUN state
//  DONE        out  1      1-cycle pulse when EDGE_COUNT reaches the target
//  EDGE_COUNT  out  WIDTH  current edge count, 0..4*MAX_CLICKS (clicks = EDGE_COUNT>>2)
// BEHAVIOUR
//  - Reset: A=0, B=0, BUSY=0, DONE=0, EDGE_COUNT=0, target_q=0, divider=0, state=IDLE.
//    Reset has priority over everything; mid-motion reset abandons the move and emits no DONE.
//  - Target latch: target_q = 4*min(TARGET, MAX_CLICKS), computed at WIDTH bits.
//    4*MAX_CLICKS must fit in WIDTH.
//  - Phase: EDGE_COUNT[1:0] fixes {A,B}: 0->00, 1->10, 2->11, 3->01.
//    Increasing count means A leads B. A/B are registered in the same cycle as EDGE_COUNT.
//  - FSM, 2 states:
//    IDLE: LOAD=1 -> latch target_q, divider=STEP_DIV-1, go to RUN. Otherwise hold.
//    RUN, priority order:
//      (a) EDGE_COUNT==target_q -> DONE=1 for this cycle, go to IDLE.
//      (b) else divider==0 -> EDGE_COUNT +/-1 toward target_q, divider=STEP_DIV-1.
//      (c) else divider decrements.
//    BUSY=1 exactly while state==RUN.
//  - Timing: LOAD sampled at edge k -> BUSY=1 from edge k.
//    First A/B change at edge k+STEP_DIV, then one every STEP_DIV cycles.
//    DONE is high in the cycle after the final A/B change; BUSY falls at the same edge.
//  - Zero move: LOAD with clamped target == EDGE_COUNT -> RUN for 1 cycle, DONE at edge k+1,
//    no A/B change.
//  - Retarget: LOAD during RUN re-latches target_q and keeps the divider phase.
//    Direction is re-evaluated at the next step; a step due in the LOAD cycle uses the old target_q.
//    Case (a) uses the new target_q from the following cycle.
//  - LOAD in the same cycle as case (a): DONE still pulses and the state goes to IDLE.
//    The new target is latched and the state goes to RUN on the next cycle.
//  - Edge rate: at most one edge per STEP_DIV cycles, never two per cycle.
//    EDGE_COUNT never leaves 0..4*MAX_CLICKS and has no wrap-around.
// STRUCTURE
//  - Shared include pong_defs.vh holds:
//    EDGES_PER_CLICK=4, the phase->{A,B} constants (00,10,11,01), and the IDLE/RUN state encodings.
//  - One sub-module, step_timer: reload-to-STEP_DIV-1 down-counter with load/enable inputs
//    and a tick output.
//  - The FSM, edge counter and A/B registers stay in quadrature_encoder.
// TESTING (STEP_DIV=4, MAX_CLICKS=25, WIDTH=8)
//  1. Hold RESET 3 cycles -> A=0, B=0, BUSY=0, DONE=0, EDGE_COUNT=0.
//  2. LOAD, TARGET=1 at edge 0 -> AB=10,11,01,00 at edges 4,8,12,16; EDGE_COUNT=4;
//     DONE at edge 17. Loopback through the player path -> POSITION=1.
//  3. Then LOAD, TARGET=0 -> AB=01,11,10,00 at 4-cycle spacing; EDGE_COUNT=0; one DONE.
//  4. LOAD, TARGET=200 -> clamps to 25 clicks; exactly 100 edges; EDGE_COUNT=100;
//     loopback POSITION=25.
//  5. LOAD, TARGET=5; after 6 edges, LOAD, TARGET=0 -> no DONE at count 20; count reverses;
//     edge spacing stays 4 cycles; ends at 0 with a single DONE.
//  6. Assert RESET at EDGE_COUNT=7 -> next cycle all outputs 0, no DONE.
//     Then LOAD, TARGET=0 -> DONE at edge k+1 with no A/B activity.

Source files
------------

// File: rtl/quadrature_encoder_pkg.sv
// Shared constants for the quadrature encoder: edges per click, the
// phase-to-{A,B} table and the controller state encoding.
package quadrature_encoder_pkg;

    localparam int EDGES_PER_CLICK = 4;

    localparam logic [1:0] PHASE_AB_0 = 2'b00;
    localparam logic [1:0] PHASE_AB_1 = 2'b10;
    localparam logic [1:0] PHASE_AB_2 = 2'b11;
    localparam logic [1:0] PHASE_AB_3 = 2'b01;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } enc_state_t;

    function automatic logic [1:0] phase_ab(input logic [1:0] phase);
        logic [1:0] ab;
        case (phase)
            2'd0:    ab = PHASE_AB_0;
            2'd1:    ab = PHASE_AB_1;
            2'd2:    ab = PHASE_AB_2;
            default: ab = PHASE_AB_3;
        endcase
        return ab;
    endfunction

endpackage

// File: rtl/quadrature_encoder_if.sv
// Command/status bundle of the quadrature encoder; the controller side is the
// slave, whoever commands positions is the master.
interface quadrature_encoder_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] TARGET;
    logic             LOAD;
    logic             A;
    logic             B;
    logic             BUSY;
    logic             DONE;
    logic [WIDTH-1:0] EDGE_COUNT;

    modport master (
        output TARGET, LOAD,
        input  A, B, BUSY, DONE, EDGE_COUNT
    );

    modport slave (
        input  TARGET, LOAD,
        output A, B, BUSY, DONE, EDGE_COUNT
    );
endinterface

// File: rtl/quadrature_encoder_step_timer.sv
// Edge-rate down-counter: reloads to STEP_DIV-1 on load or after reaching
// zero while enabled; tick marks the zero count.
module quadrature_encoder_step_timer #(
    parameter int STEP_DIV = 1000
) (
    input  logic CLOCK,
    input  logic RESET,
    input  logic load,
    input  logic en,
    output logic tick
);
    localparam int            CW     = $clog2(STEP_DIV);
    localparam logic [CW-1:0] RELOAD = CW'(STEP_DIV - 1);

    logic [CW-1:0] count_q;

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            count_q <= '0;
        end else if (load || (en && count_q == '0)) begin
            count_q <= RELOAD;
        end else if (en) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign tick = (count_q == '0);

endmodule

// File: rtl/quadrature_encoder.sv
// Quadrature A/B generator: walks a Gray-coded edge counter toward the
// commanded click position, one edge every STEP_DIV clocks.
//
// state   | meaning
// ST_IDLE | holding position, waiting for LOAD (or a LOAD that collided with DONE)
// ST_RUN  | stepping edge_q toward target_q, BUSY high
module quadrature_encoder #(
    parameter int STEP_DIV   = 1000,
    parameter int MAX_CLICKS = 25,
    parameter int WIDTH      = 8
) (
    input  logic                CLOCK,
    input  logic                RESET,
    quadrature_encoder_if.slave bus
);
    import quadrature_encoder_pkg::*;

    enc_state_t       state_q, state_d;
    logic [WIDTH-1:0] edge_q, edge_d;
    logic [WIDTH-1:0] target_q;
    logic [WIDTH-1:0] target_clamped;
    logic [WIDTH-1:0] target_edges;
    logic [1:0]       ab_q;
    logic             done_q, done_d;
    logic             pend_q, pend_d;
    logic             latch_tgt;
    logic             timer_load;
    logic             timer_en;
    logic             tick;
    logic             step;
    logic             at_target;

    assign target_clamped = (bus.TARGET > WIDTH'(MAX_CLICKS)) ? WIDTH'(MAX_CLICKS) : bus.TARGET;
    assign target_edges   = target_clamped * WIDTH'(EDGES_PER_CLICK);
    assign at_target      = (edge_q == target_q);

    quadrature_encoder_step_timer #(
        .STEP_DIV (STEP_DIV)
    ) u_step_timer (
        .CLOCK (CLOCK),
        .RESET (RESET),
        .load  (timer_load),
        .en    (timer_en),
        .tick  (tick)
    );

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        done_d     = 1'b0;
        pend_d     = 1'b0;
        latch_tgt  = 1'b0;
        timer_load = 1'b0;
        timer_en   = 1'b0;
        step       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // A pending LOAD already latched its target on the DONE cycle
                if (bus.LOAD || pend_q) begin
                    state_d    = ST_RUN;
                    timer_load = 1'b1;
                    latch_tgt  = bus.LOAD;
                end
            end
            ST_RUN: begin
                latch_tgt = bus.LOAD;
                if (at_target) begin
                    done_d  = 1'b1;
                    pend_d  = bus.LOAD;
                    state_d = ST_IDLE;
                end else begin
                    timer_en = 1'b1;
                    step     = tick;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Direction uses the target in force before this edge, so a retarget
    // only affects steps after the LOAD cycle.
    always_comb begin
        edge_d = edge_q;
        if (step) begin
            edge_d = (edge_q < target_q) ? edge_q + 1'b1 : edge_q - 1'b1;
        end
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            edge_q   <= '0;
            target_q <= '0;
            ab_q     <= 2'b00;
            done_q   <= 1'b0;
            pend_q   <= 1'b0;
        end else begin
            edge_q <= edge_d;
            ab_q   <= phase_ab(edge_d[1:0]);
            done_q <= done_d;
            pend_q <= pend_d;
            if (latch_tgt) begin
                target_q <= target_edges;
            end
        end
    end

    assign bus.A          = ab_q[1];
    assign bus.B          = ab_q[0];
    assign bus.BUSY       = (state_q == ST_RUN);
    assign bus.DONE       = done_q;
    assign bus.EDGE_COUNT = edge_q;

endmodule

// File: tb/tb_quadrature_encoder.sv
// Bench for quadrature_encoder: directed moves plus random LOAD/RESET traffic
// against a position/target model and an independent A/B decoder.
module tb_quadrature_encoder;
    localparam int STEP_DIV   = 4;
    localparam int MAX_CLICKS = 25;
    localparam int WIDTH      = 8;

    logic CLOCK = 1'b0;
    logic RESET = 1'b1;
    always #5 CLOCK = ~CLOCK;

    quadrature_encoder_if #(.WIDTH(WIDTH)) bus ();

    quadrature_encoder #(
        .STEP_DIV   (STEP_DIV),
        .MAX_CLICKS (MAX_CLICKS),
        .WIDTH      (WIDTH)
    ) dut (
        .CLOCK (CLOCK),
        .RESET (RESET),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // reference model: position, target (both in edges), cycles to next step
    int m_pos = 0, m_tgt = 0, m_wait = 0;
    bit m_run = 0, m_done = 0, m_pend = 0;

    // run statistics
    int cyc = 0, k_load = 0;
    int n_changes, n_done, first_change, last_change, done_at, spacing_bad, max_edge;
    int dec_count = 0, bad_gray = 0;
    logic [1:0] prev_ab = 2'b00;
    logic [1:0] ab_seq[$];
    bit timed_out;

    function automatic logic [1:0] exp_ab(input int pos);
        case (pos % 4)
            0:       return 2'b00;
            1:       return 2'b10;
            2:       return 2'b11;
            default: return 2'b01;
        endcase
    endfunction

    function automatic int ab_idx(input logic [1:0] ab);
        case (ab)
            2'b00:   return 0;
            2'b10:   return 1;
            2'b11:   return 2;
            default: return 3;
        endcase
    endfunction

    task automatic model_edge();
        int t;
        t = int'(bus.TARGET);
        if (t > MAX_CLICKS) t = MAX_CLICKS;
        t = 4 * t;
        if (RESET) begin
            m_pos = 0; m_tgt = 0; m_wait = 0; m_run = 0; m_done = 0; m_pend = 0;
        end else begin
            m_done = 0;
            if (!m_run) begin
                if (bus.LOAD || m_pend) begin
                    m_run  = 1;
                    m_wait = STEP_DIV - 1;
                    if (bus.LOAD) m_tgt = t;
                end
                m_pend = 0;
            end else if (m_pos == m_tgt) begin
                m_done = 1;
                m_run  = 0;
                m_pend = bus.LOAD;
                if (bus.LOAD) m_tgt = t;
            end else begin
                if (m_wait == 0) begin
                    m_pos  = m_pos + ((m_pos < m_tgt) ? 1 : -1);
                    m_wait = STEP_DIV - 1;
                end else begin
                    m_wait--;
                end
                if (bus.LOAD) m_tgt = t;
            end
        end
    endtask

    task automatic clear_stats();
        n_changes = 0; n_done = 0; first_change = -1; last_change = -1;
        done_at = -1; spacing_bad = 0; max_edge = 0;
        ab_seq.delete();
    endtask

    task automatic step_cycle();
        logic [1:0] ab;
        int d;
        @(posedge CLOCK);
        model_edge();
        cyc++;
        #1;
        ab = {bus.A, bus.B};
        chk("outputs", {ab, bus.BUSY, bus.DONE, bus.EDGE_COUNT},
            {exp_ab(m_pos), m_run, m_done, WIDTH'(m_pos)});
        if (RESET) begin
            dec_count = 0;
        end else begin
            d = (ab_idx(ab) - ab_idx(prev_ab)) & 3;
            if (d == 1) dec_count++;
            else if (d == 3) dec_count--;
            else if (d == 2) bad_gray++;
            if (ab != prev_ab) begin
                n_changes++;
                ab_seq.push_back(ab);
                if (last_change >= 0 && cyc - last_change != STEP_DIV) spacing_bad++;
                if (first_change < 0) first_change = cyc - k_load;
                last_change = cyc;
            end
        end
        if (bus.DONE) begin
            n_done++;
            if (done_at < 0) done_at = cyc - k_load;
        end
        if (int'(bus.EDGE_COUNT) > max_edge) max_edge = int'(bus.EDGE_COUNT);
        prev_ab = ab;
    endtask

    task automatic do_load(input int tgt);
        bus.TARGET = WIDTH'(tgt);
        bus.LOAD   = 1'b1;
        k_load     = cyc + 1;
        step_cycle();
        bus.LOAD   = 1'b0;
    endtask

    task automatic run_until(input int stop_changes, input int budget);
        int start_done = n_done;
        int n = 0;
        timed_out = 0;
        while (1) begin
            if (n >= budget) begin
                timed_out = 1;
                break;
            end
            step_cycle();
            n++;
            if (n_done > start_done) break;
            if (stop_changes > 0 && n_changes >= stop_changes) break;
        end
        chk("no_timeout", timed_out, 0);
    endtask

    function automatic logic [7:0] first4_ab();
        if (ab_seq.size() < 4) return 8'h00;
        return {ab_seq[0], ab_seq[1], ab_seq[2], ab_seq[3]};
    endfunction

    initial begin
        bus.LOAD   = 1'b0;
        bus.TARGET = '0;
        RESET      = 1'b1;
        clear_stats();

        // 1: reset
        repeat (3) step_cycle();
        chk("t1_reset", {bus.A, bus.B, bus.BUSY, bus.DONE, bus.EDGE_COUNT}, 0);
        RESET = 1'b0;
        step_cycle();

        // 2: one click forward
        clear_stats();
        do_load(1);
        run_until(0, 100);
        chk("t2_first", first_change, 4);
        chk("t2_changes", n_changes, 4);
        chk("t2_spacing", spacing_bad, 0);
        chk("t2_ab", first4_ab(), 8'b10_11_01_00);
        chk("t2_done_at", done_at, 17);
        chk("t2_busy", bus.BUSY, 0);
        chk("t2_count", bus.EDGE_COUNT, 4);
        chk("t2_pos", dec_count >>> 2, 1);
        step_cycle();
        chk("t2_pulse", bus.DONE, 0);

        // 3: back to zero
        clear_stats();
        do_load(0);
        run_until(0, 100);
        repeat (8) step_cycle();
        chk("t3_ab", first4_ab(), 8'b01_11_10_00);
        chk("t3_count", bus.EDGE_COUNT, 0);
        chk("t3_done", n_done, 1);

        // 4: clamped target
        clear_stats();
        do_load(200);
        run_until(0, 600);
        chk("t4_changes", n_changes, 100);
        chk("t4_count", bus.EDGE_COUNT, 100);
        chk("t4_pos", dec_count >>> 2, 25);
        chk("t4_spacing", spacing_bad, 0);

        // 5: retarget mid-move reverses direction
        do_load(0);
        run_until(0, 600);
        clear_stats();
        do_load(5);
        run_until(6, 100);
        chk("t5_mid", bus.EDGE_COUNT, 6);
        do_load(0);
        run_until(0, 200);
        repeat (8) step_cycle();
        chk("t5_done", n_done, 1);
        chk("t5_max", max_edge, 6);
        chk("t5_changes", n_changes, 12);
        chk("t5_spacing", spacing_bad, 0);
        chk("t5_count", bus.EDGE_COUNT, 0);

        // 7: LOAD lands on the DONE cycle
        clear_stats();
        do_load(2);
        run_until(8, 100);
        do_load(1);
        chk("t7_collide", {bus.BUSY, bus.DONE}, 2'b01);
        step_cycle();
        chk("t7_restart", bus.BUSY, 1);
        run_until(0, 100);
        chk("t7_done", n_done, 2);
        chk("t7_count", bus.EDGE_COUNT, 4);

        // 6: reset mid-move, then zero move
        do_load(0);
        run_until(0, 100);
        clear_stats();
        do_load(5);
        run_until(7, 100);
        chk("t6_mid", bus.EDGE_COUNT, 7);
        RESET = 1'b1;
        step_cycle();
        RESET = 1'b0;
        chk("t6_reset", {bus.A, bus.B, bus.BUSY, bus.DONE, bus.EDGE_COUNT}, 0);
        repeat (3) step_cycle();
        chk("t6_no_done", n_done, 0);
        clear_stats();
        do_load(0);
        run_until(0, 20);
        chk("t6_zero_done_at", done_at, 1);
        chk("t6_zero_changes", n_changes, 0);

        // random LOAD / RESET traffic
        for (int i = 0; i < 150; i++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 3) begin
                RESET = 1'b1;
                step_cycle();
                RESET = 1'b0;
            end else if (r < 60) begin
                bus.TARGET = (r < 10) ? WIDTH'($urandom_range(26, 255))
                                      : WIDTH'($urandom_range(0, 30));
                bus.LOAD = 1'b1;
                step_cycle();
                bus.LOAD = 1'b0;
            end
            repeat ($urandom_range(1, 40)) step_cycle();
        end
        chk("rand_pos", dec_count, int'(bus.EDGE_COUNT));
        chk("gray", bad_gray, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
